// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with a byte FIFO in front of the
// shifter. The core writes bytes into the FIFO. The shifter drains it one frame
// at a time (start bit, 8 data bits LSB first, stop bit). Each bit lasts
// COUNT_MAX+1 clocks. Frames run back to back while the FIFO has data.
//
// Ports:
//   CLK    system clock, all logic on posedge
//   RST    synchronous active-high reset
//   in     byte to send
//   valid  write strobe, byte taken on a posedge with valid && ready
//   ready  FIFO not full
//   out    serial TX line, idle high, registered
//   busy   FIFO non-empty or a frame in progress
module uart_transmitter #(
    parameter int                     COUNT_WIDTH = 12,
    parameter logic [COUNT_WIDTH-1:0] COUNT_MAX   = 12'd2603,
    parameter int                     FIFO_LOG2   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] in,
    input  logic       valid,
    output logic       ready,
    output logic       out,
    output logic       busy
);

    localparam int                 DEPTH   = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] DEPTH_C = (FIFO_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO storage and bookkeeping
    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_LOG2-1:0] r_wptr;
    logic [FIFO_LOG2-1:0] r_rptr;
    logic [FIFO_LOG2:0]   r_count;

    // Shifter
    state_t               r_state;
    logic [7:0]           r_shift;
    logic [2:0]           r_idx;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic                 r_out;

    logic w_nonempty;
    logic w_push;
    logic w_pop;
    logic w_bit_end;

    assign w_nonempty = (r_count != '0);
    assign ready      = (r_count != DEPTH_C);
    assign w_push     = valid && ready;
    assign w_bit_end  = (r_cnt == COUNT_MAX);
    // The shifter takes a byte either from idle or at the end of a stop bit.
    // Popping at the end of the stop bit keeps consecutive frames gap-free.
    assign w_pop      = w_nonempty &&
                        ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    assign out  = r_out;
    assign busy = (r_state != IDLE) || w_nonempty;

    // FIFO storage. No reset is needed because the pointers define validity.
    always_ff @(posedge CLK) begin
        if (!RST && w_push)
            r_mem[r_wptr] <= in;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame FSM. The line level is registered from the current state, so out
    // trails the state by one clock. Every bit still lasts COUNT_MAX+1 clocks.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_out   <= 1'b1;
        end else begin
            case (r_state)
                IDLE:  r_out <= 1'b1;
                START: r_out <= 1'b0;
                DATA:  r_out <= r_shift[0];
                STOP:  r_out <= 1'b1;
                default: r_out <= 1'b1;
            endcase

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_idx == 3'd7)
                            r_state <= STOP;
                        else
                            r_idx <= r_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rptr];
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: a transaction-level model predicts FIFO acceptance and
// the edge at which each frame starts. A line monitor decodes whole frames
// from the TX pin and checks them against the scoreboard of expected frames.
// A second instance with default timing checks the real bit period.
module tb_uart_transmitter;

    localparam int CPB   = 4;          // clocks per bit for the fast instance
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] din = '0;
    logic       valid = 1'b0;
    logic       ready, out, busy;
    logic [7:0] din2 = '0;
    logic       valid2 = 1'b0;
    logic       ready2, out2, busy2;

    always #5 CLK = ~CLK;

    uart_transmitter #(.COUNT_WIDTH(12), .COUNT_MAX(12'd3), .FIFO_LOG2(4)) dut (
        .CLK(CLK), .RST(RST), .in(din), .valid(valid),
        .ready(ready), .out(out), .busy(busy));

    uart_transmitter dut2 (
        .CLK(CLK), .RST(RST), .in(din2), .valid(valid2),
        .ready(ready2), .out(out2), .busy(busy2));

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame popped at edge p shows its start bit from edge p+1. The next pop
    // may happen no earlier than edge p+FRAME.
    typedef struct { logic [7:0] d; int t; } exp_t;
    logic [7:0] mq[$];
    exp_t       sb[$];
    int         m_free  = 0;
    int         m_epoch = 0;
    bit         m_ready = 1'b1;
    bit         m_busy  = 1'b0;
    bit         m_pop, m_push;
    exp_t       m_e;

    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            mq.delete();
            sb.delete();
            m_free = cyc;
            m_epoch++;
        end else begin
            m_pop  = (mq.size() != 0) && (cyc >= m_free);
            m_push = valid && (mq.size() != DEPTH);
            if (m_pop) begin
                m_e.d = mq.pop_front();
                m_e.t = cyc + 1;
                sb.push_back(m_e);
                m_free = cyc + FRAME;
            end
            if (m_push)
                mq.push_back(din);
        end
        m_ready = (mq.size() != DEPTH);
        m_busy  = (mq.size() != 0) || (cyc < m_free);
    end

    // ---------------- line monitor ----------------
    bit   mon_en = 1'b0;
    int   mon_ep = 0;
    bit   dec    = 1'b0;
    int   dn     = 0;
    int   fst    = 0;
    logic smp [FRAME];

    task automatic check_frame();
        logic [7:0] d;
        bit         ok;
        exp_t       e;
        ok = 1'b1;
        for (int b = 0; b < 10; b++)
            for (int j = 1; j < CPB; j++)
                if (smp[b*CPB+j] !== smp[b*CPB]) ok = 1'b0;
        if (smp[0] !== 1'b0 || smp[9*CPB] !== 1'b1) ok = 1'b0;
        for (int i = 0; i < 8; i++)
            d[i] = smp[(i+1)*CPB];
        chk("frame_shape", {31'd0, ok}, 32'd1);
        if (sb.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_frame got data %0h at cycle %0d expected no frame", d, fst);
        end else begin
            e = sb.pop_front();
            chk("frame_data", {24'd0, d}, {24'd0, e.d});
            chk("frame_start", fst, e.t);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            chk("ready", {31'd0, ready}, {31'd0, m_ready});
            chk("busy",  {31'd0, busy},  {31'd0, m_busy});
            if (mon_ep != m_epoch) begin
                dec    = 1'b0;
                mon_ep = m_epoch;
            end
            if (!dec) begin
                if (out !== 1'b1) begin
                    dec    = 1'b1;
                    fst    = cyc;
                    smp[0] = out;
                    dn     = 1;
                end
            end else begin
                smp[dn] = out;
                dn++;
                if (dn == FRAME) begin
                    dec = 1'b0;
                    check_frame();
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    int   k2;
    int   tr[$];
    logic prv;
    logic bA, bB;

    initial begin
        step();                 // first reset edge
        mon_en = 1'b1;
        idle(2);
        RST = 1'b0;
        idle(50);

        // single byte
        valid = 1'b1; din = 8'hA5; step(); valid = 1'b0;
        idle(60);

        // 18 consecutive writes; the last one finds the FIFO full
        for (int i = 0; i < 18; i++) begin
            valid = 1'b1; din = 8'(i); step();
        end
        valid = 1'b0;
        idle(18 * FRAME + 20);

        // fill, then keep writing so a byte lands as soon as a slot frees
        for (int i = 0; i < 17 + 60; i++) begin
            valid = 1'b1; din = 8'($urandom); step();
        end
        valid = 1'b0;
        idle(18 * FRAME + 20);

        // reset during the 4th data bit of the first frame, 5 bytes queued
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1; din = 8'($urandom); step();
        end
        valid = 1'b0;
        idle(14);
        RST = 1'b1; valid = 1'b1; din = 8'hC3; step();
        RST = 1'b0; valid = 1'b0;
        idle(80);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(0, 3) == 0);
            din   = 8'($urandom);
            step();
        end
        valid = 1'b0;
        idle(18 * FRAME + 20);

        chk("sb_empty", sb.size(), 0);
        chk("fifo_empty", mq.size(), 0);

        // default timing instance: 8'h55 toggles on every bit boundary
        valid2 = 1'b1; din2 = 8'h55; step(); valid2 = 1'b0;
        k2  = cyc;
        prv = 1'b1;
        bA  = 1'bx;
        bB  = 1'bx;
        for (int n = 0; n < 27000; n++) begin
            @(negedge CLK);
            if (out2 !== prv) begin
                tr.push_back(cyc);
                prv = out2;
            end
            if (tr.size() > 0) begin
                if (cyc == tr[0] + 26038) bA = busy2;
                if (cyc == tr[0] + 26039) bB = busy2;
                if (cyc >= tr[0] + 26045) break;
            end
        end
        chk("tx2_transitions", tr.size(), 10);
        if (tr.size() > 0) chk("tx2_start_latency", tr[0], k2 + 2);
        for (int i = 1; i < tr.size() && i < 10; i++)
            chk("tx2_bit_period", tr[i] - tr[i-1], 2604);
        chk("tx2_busy_before_end", {31'd0, bA}, 32'd1);
        chk("tx2_busy_at_end", {31'd0, bB}, 32'd0);
        chk("tx2_line_idle", {31'd0, out2}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
